// File: rtl/counter_sched.sv
`default_nettype none
// ============================================================================
// Module      : counter_sched
// Description : Round-robin scheduler that lends one interval counter to
//               NUM_REQ requesters. The winner's delay is counted out, then a
//               one-cycle done pulse is returned to that requester.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_sched #(
  parameter int NUM_REQ           = 4,
  parameter int COUNTER_BIT_WIDTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ*COUNTER_BIT_WIDTH-1:0] req_cycles,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [NUM_REQ-1:0]                   done,
  output logic                                 busy,
  output logic [$clog2(NUM_REQ)-1:0]           grant_id,
  output logic [COUNTER_BIT_WIDTH-1:0]         count_value
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int W   = COUNTER_BIT_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [W-1:0]       target_q, target_d;
  logic [W-1:0]       count_q, count_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;

  logic               win_found;
  logic [IDW-1:0]     win_idx;
  logic [IDW:0]       scan_idx;
  logic [W-1:0]       win_cycles;

  // Round-robin pick in IDLE: first valid requester at or after the pointer.
  // Nothing is offered while reset is held so no handshake can slip through.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    req_ready = '0;
    if (state_q == S_IDLE && rst_n) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = {1'b0, ptr_q} + (IDW+1)'(k);
        if (scan_idx >= (IDW+1)'(NUM_REQ)) begin
          scan_idx = scan_idx - (IDW+1)'(NUM_REQ);
        end
        if (!win_found && req_valid[scan_idx[IDW-1:0]]) begin
          win_found = 1'b1;
          win_idx   = scan_idx[IDW-1:0];
        end
      end
      req_ready[win_idx] = win_found;
    end
  end

  // Next-state logic: latch the grant, count to target-1, then pulse done.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    count_d    = count_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    win_cycles = req_cycles[int'(win_idx)*W +: W];
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          // A zero-cycle request is stretched to one so done is never skipped.
          target_d   = (win_cycles == '0) ? W'(1) : win_cycles;
          grant_id_d = win_idx;
          ptr_d      = (win_idx == IDW'(NUM_REQ-1)) ? '0 : win_idx + IDW'(1);
          count_d    = '0;
          state_d    = S_COUNT;
        end
      end
      S_COUNT: begin
        // Holding at target-1 keeps the counter from ever wrapping.
        if (count_q == target_q - W'(1)) begin
          state_d = S_DONE;
        end else begin
          count_d = count_q + W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        count_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = '0;
    if (state_d == S_DONE) begin
      done_d[grant_id_d] = 1'b1;
    end
  end

  // State and registered outputs; async reset drops any interval in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      count_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      count_q    <= count_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign done        = done_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;
  assign count_value = count_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_sched
// Description : Self-checking bench for counter_sched (4 requesters, 8-bit
//               counter): vector table, directed corner sequences and a
//               randomized run against a timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_sched;

  localparam int NR = 4;
  localparam int W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid;
  logic [NR*W-1:0]   req_cycles;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     done;
  logic              busy;
  logic [1:0]        grant_id;
  logic [W-1:0]      count_value;

  int checks   = 0;
  int failures = 0;

  // reference model: the last grant as a point on the timeline
  bit m_has;
  int m_T, m_N, m_gid, m_ptr, cyc;

  typedef struct {
    logic [NR-1:0]   mask;
    logic [NR*W-1:0] cyc;
    int              win;
    int              delay;
    int              peak;
  } vec_t;

  vec_t tbl [7];

  always #5 clk = ~clk;

  counter_sched #(.NUM_REQ(NR), .COUNTER_BIT_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_cycles (req_cycles),
    .req_ready  (req_ready),
    .done       (done),
    .busy       (busy),
    .grant_id   (grant_id),
    .count_value(count_value)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) begin
      if (v[(p+k)%NR]) return (p+k)%NR;
    end
    return -1;
  endfunction

  function automatic int eff(input int c);
    return (c == 0) ? 1 : c;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_has = 1'b0; m_ptr = 0; m_gid = 0; m_T = 0; m_N = 1; cyc = 0;
  endtask

  // One cycle against the model: inputs already driven for this cycle.
  task automatic cycle_check();
    logic [NR-1:0] e_ready, e_done;
    logic e_busy;
    int e_cnt, d, w;
    @(negedge clk);
    e_ready = '0; e_done = '0; e_busy = 1'b0; e_cnt = 0; w = -1;
    d = cyc - m_T;
    if (!m_has || d >= m_N + 2) begin
      w = rr_pick(req_valid, m_ptr);
      if (w >= 0) e_ready[w] = 1'b1;
    end else if (d <= m_N) begin
      e_busy = 1'b1; e_cnt = d - 1;
    end else begin
      e_busy = 1'b1; e_cnt = m_N - 1; e_done[m_gid] = 1'b1;
    end
    chk("rnd_ready", 32'(req_ready), 32'(e_ready));
    chk("rnd_done",  32'(done),      32'(e_done));
    chk("rnd_busy",  32'(busy),      32'(e_busy));
    chk("rnd_count", 32'(count_value), 32'(e_cnt));
    chk("rnd_gid",   32'(grant_id),  32'(m_gid));
    if (w >= 0) begin
      m_has = 1'b1; m_T = cyc; m_gid = w; m_ptr = (w + 1) % NR;
      m_N = eff(int'(req_cycles[w*W +: W]));
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    int found, tdone, peak, nbusy;
    logic [NR-1:0] dseen, dor;
    int order[$];
    int times[$];

    req_valid  = '0;
    req_cycles = '0;

    tbl[0] = '{4'b0001, {8'd0,   8'd0, 8'd0, 8'd5}, 0, 6,   4};
    tbl[1] = '{4'b0100, {8'd0,   8'd0, 8'd0, 8'd0}, 2, 2,   0};
    tbl[2] = '{4'b0011, {8'd0,   8'd0, 8'd4, 8'd4}, 0, 5,   3};
    tbl[3] = '{4'b1001, {8'd255, 8'd0, 8'd0, 8'd9}, 3, 256, 254};
    tbl[4] = '{4'b1110, {8'd1,   8'd1, 8'd1, 8'd0}, 1, 2,   0};
    tbl[5] = '{4'b0011, {8'd0,   8'd0, 8'd7, 8'd7}, 0, 8,   6};
    tbl[6] = '{4'b1111, {8'd2,   8'd2, 8'd2, 8'd2}, 1, 3,   1};

    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_gid",   32'(grant_id), 0);
    chk("rst_count", 32'(count_value), 0);
    @(posedge clk); #1;

    // vector table: one request set per entry, pointer carried across entries
    for (int i = 0; i < 7; i++) begin
      req_valid  = tbl[i].mask;
      req_cycles = tbl[i].cyc;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(1 << tbl[i].win));
      found = 0; tdone = 0; peak = 0; nbusy = 0; dseen = '0;
      for (int k = 1; k <= 400 && found == 0; k++) begin
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        if (busy) nbusy++;
        if (int'(count_value) > peak) peak = int'(count_value);
        if (done != '0) begin found = 1; tdone = k; dseen = done; end
      end
      chk($sformatf("vec%0d_delay", i), 32'(tdone), 32'(tbl[i].delay));
      chk($sformatf("vec%0d_done", i),  32'(dseen), 32'(1 << tbl[i].win));
      chk($sformatf("vec%0d_peak", i),  32'(peak),  32'(tbl[i].peak));
      chk($sformatf("vec%0d_busy", i),  32'(nbusy), 32'(tbl[i].delay));
      chk($sformatf("vec%0d_gid", i),   32'(grant_id), 32'(tbl[i].win));
      @(posedge clk); #1;
    end

    // all four requesting continuously: 0,1,2,3 twice, 5 cycles apart
    do_reset();
    req_valid  = 4'hF;
    req_cycles = {4{8'd3}};
    for (int k = 0; k < 60 && order.size() < 8; k++) begin
      @(negedge clk);
      if (done != '0) begin
        order.push_back($clog2(done));
        times.push_back(k);
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    chk("rr_count", 32'(order.size()), 8);
    if (times.size() > 0) chk("rr_first_done", 32'(times[0]), 4);
    for (int i = 0; i < order.size(); i++) begin
      chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % NR));
      if (i > 0) chk($sformatf("rr_gap%0d", i), 32'(times[i] - times[i-1]), 5);
    end

    // reset in the middle of a 10-cycle interval
    do_reset();
    req_valid  = 4'b0100;
    req_cycles = {8'd0, 8'd10, 8'd0, 8'd0};
    @(negedge clk);
    chk("mid_ready", 32'(req_ready), 32'(4'b0100));
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_count", 32'(count_value), 1);
    chk("mid_gid",   32'(grant_id), 2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  32'(busy), 0);
    chk("mid_rst_count", 32'(count_value), 0);
    chk("mid_rst_gid",   32'(grant_id), 0);
    chk("mid_rst_done",  32'(done), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dor = '0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      dor = dor | done;
      if (busy) dor[0] = 1'b1;
      @(posedge clk); #1;
    end
    chk("mid_no_done", 32'(dor), 0);
    req_valid = 4'hF;
    @(negedge clk);
    chk("mid_ptr0", 32'(req_ready), 32'(4'b0001));
    @(posedge clk); #1;
    req_valid = '0;

    // req 1 waits through grant 3; req 2 drops out before being served
    do_reset();
    req_valid  = 4'b1000;
    req_cycles = {8'd2, 8'd0, 8'd0, 8'd0};
    @(negedge clk);
    chk("wait_ready3", 32'(req_ready), 32'(4'b1000));
    @(posedge clk); #1;
    req_valid = 4'b0110;
    @(posedge clk); #1;
    req_valid = 4'b0010;
    @(posedge clk); #1;
    @(negedge clk);
    chk("wait_done3",  32'(done), 32'(4'b1000));
    chk("wait_noready", 32'(req_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wait_ready1", 32'(req_ready), 32'(4'b0010));
    chk("wait_idle",   32'(busy), 0);
    @(posedge clk); #1;
    req_valid = '0;
    dor = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      dor = dor | done;
      @(posedge clk); #1;
    end
    chk("wait_done1_only", 32'(dor), 32'(4'b0010));

    // randomized traffic against the timeline model, with one reset midway
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      req_valid = NR'($urandom);
      if ($urandom_range(0, 3) == 0) req_valid = '0;
      for (int i = 0; i < NR; i++) begin
        req_cycles[i*W +: W] = ($urandom_range(0, 31) == 0) ? 8'd255 : W'($urandom_range(0, 6));
      end
      cycle_check();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
